// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC cores: Q3.13 angle constants, the arctan
// table and the Q1.15 inverse gain.
package cordic_pkg;

  localparam int QFRAC      = 13;
  localparam int PI         = 25736;
  localparam int HALF_PI    = 12868;
  localparam int INV_K      = 19899;
  localparam int INV_K_FRAC = 15;

  // atan(2^-i) in Q3.13; deeper stages bottom out at one LSB
  function automatic int atan_q13(input int i);
    case (i)
      0:       return 6434;
      1:       return 3798;
      2:       return 2007;
      3:       return 1019;
      4:       return 511;
      5:       return 256;
      6:       return 128;
      7:       return 64;
      8:       return 32;
      9:       return 16;
      10:      return 8;
      11:      return 4;
      12:      return 2;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/cordic_vectoring_if.sv
// Enable/done handshake and data bus shared by the CORDIC cores.
interface cordic_vectoring_if #(
  parameter int data_width = 16
);
  logic                         enable;
  logic signed [data_width-1:0] xin;
  logic signed [data_width-1:0] yin;
  logic                         done;
  logic signed [data_width-1:0] xout;
  logic signed [data_width-1:0] zout;

  modport master (output enable, xin, yin, input done, xout, zout);
  modport slave  (input enable, xin, yin, output done, xout, zout);
endinterface

// File: rtl/cordic_vec_stage.sv
// One vectoring micro-rotation register: drives y toward zero and
// accumulates the rotated angle into z.
module cordic_vec_stage #(
  parameter int W     = 19,
  parameter int ZW    = 16,
  parameter int SHIFT = 0,
  parameter int ATAN  = 6434
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic signed [W-1:0]  x_i,
  input  logic signed [W-1:0]  y_i,
  input  logic signed [ZW-1:0] z_i,
  input  logic                 zf_i,
  output logic signed [W-1:0]  x_o,
  output logic signed [W-1:0]  y_o,
  output logic signed [ZW-1:0] z_o,
  output logic                 zf_o
);
  localparam logic signed [ZW-1:0] ATAN_V = ZW'(ATAN);

  logic signed [W-1:0] xs, ys;
  assign xs = x_i >>> SHIFT;
  assign ys = y_i >>> SHIFT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_o  <= '0;
      y_o  <= '0;
      z_o  <= '0;
      zf_o <= 1'b0;
    end else if (en) begin
      zf_o <= zf_i;
      if (y_i[W-1]) begin
        x_o <= x_i - ys;
        y_o <= y_i + xs;
        z_o <= z_i - ATAN_V;
      end else begin
        x_o <= x_i + ys;
        y_o <= y_i - xs;
        z_o <= z_i + ATAN_V;
      end
    end
  end
endmodule

// File: rtl/cordic_vectoring.sv
// Pipelined circular CORDIC, vectoring mode: (xin, yin) -> (|v|, atan2).
// Define CORDIC_GAIN_COMP_EN to scale the magnitude by 1/K in the output stage.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int data_width = 16,
  parameter int iterations = 14,
  parameter int guard_bits = 3
) (
  input  logic             clk,
  input  logic             reset,
  cordic_vectoring_if.slave vif
);
  localparam int W      = data_width + guard_bits;
  localparam int PW     = W + INV_K_FRAC + 2;
  localparam int STAGES = iterations + 1;

  localparam logic signed [data_width-1:0] PI_Z  = data_width'(PI);
  localparam logic signed [data_width-1:0] HPI_Z = data_width'(HALF_PI);
  localparam logic signed [PW-1:0] SAT_HI = {{(PW-data_width+1){1'b0}}, {(data_width-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

  logic [STAGES:0]                     vld_pipe;
  logic [iterations:0][W-1:0]          xp, yp;
  logic [iterations:0][data_width-1:0] zp;
  logic [iterations:0]                 zf;

  logic signed [W-1:0]          xe, ye, x0, y0;
  logic signed [data_width-1:0] z0;
  logic                         zf0;

  assign xe = {{guard_bits{vif.xin[data_width-1]}}, vif.xin};
  assign ye = {{guard_bits{vif.yin[data_width-1]}}, vif.yin};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:0], vif.enable};
  end

  // Fold the left half-plane into the right one so the micro-rotations converge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0  <= '0;
      y0  <= '0;
      z0  <= '0;
      zf0 <= 1'b0;
    end else if (vif.enable) begin
      zf0 <= (vif.xin == '0) && (vif.yin == '0);
      if (!vif.xin[data_width-1]) begin
        x0 <= xe;
        y0 <= ye;
        z0 <= '0;
      end else if (!vif.yin[data_width-1]) begin
        x0 <= ye;
        y0 <= -xe;
        z0 <= HPI_Z;
      end else begin
        x0 <= -ye;
        y0 <= xe;
        z0 <= -HPI_Z;
      end
    end
  end

  assign xp[0] = x0;
  assign yp[0] = y0;
  assign zp[0] = z0;
  assign zf[0] = zf0;

  for (genvar i = 0; i < iterations; i++) begin : g_stage
    cordic_vec_stage #(
      .W     (W),
      .ZW    (data_width),
      .SHIFT (i),
      .ATAN  (atan_q13(i))
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (vld_pipe[i]),
      .x_i   (xp[i]),
      .y_i   (yp[i]),
      .z_i   (zp[i]),
      .zf_i  (zf[i]),
      .x_o   (xp[i+1]),
      .y_o   (yp[i+1]),
      .z_o   (zp[i+1]),
      .zf_o  (zf[i+1])
    );
  end

  // The residual y is only a convergence by-product.
  logic unused_y;
  assign unused_y = ^yp[iterations];

  logic signed [W-1:0]          xf;
  logic signed [data_width-1:0] zfin;
  logic signed [PW-1:0]         mag;

  assign xf   = xp[iterations];
  assign zfin = zp[iterations];

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [PW-1:0] INV_K_W = PW'(INV_K);
  localparam logic signed [PW-1:0] RND     = PW'(1 << (INV_K_FRAC - 1));
  logic signed [PW-1:0] prod;
  assign prod = PW'(xf) * INV_K_W + RND;
  assign mag  = prod >>> INV_K_FRAC;
`else
  assign mag = PW'(xf);
`endif

  logic signed [data_width-1:0] xsat, zwrap;

  always_comb begin
    xsat = mag[data_width-1:0];
    if (mag > SAT_HI)      xsat = SAT_HI[data_width-1:0];
    else if (mag < SAT_LO) xsat = SAT_LO[data_width-1:0];
    // -pi and +pi are the same angle; report the (-pi, pi] representative
    zwrap = (zfin == -PI_Z) ? PI_Z : zfin;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vif.xout <= '0;
      vif.zout <= '0;
    end else if (vld_pipe[iterations]) begin
      vif.xout <= zf[iterations] ? '0 : xsat;
      vif.zout <= zf[iterations] ? '0 : zwrap;
    end
  end

  assign vif.done = vld_pipe[STAGES];

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring: latency, quadrants, saturation,
// zero vector, streaming with bubbles and asynchronous reset.
module tb_cordic_vectoring;
  localparam int DW  = 16;
  localparam int IT  = 14;
  localparam int LAT = IT + 2;
  localparam int NV  = 21;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int MAG1 = 8192;
  localparam int MAGD = 11585;
`else
  localparam int MAG1 = 13491;
  localparam int MAGD = 19078;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  real  kgain    = 1.0;

  cordic_vectoring_if #(.data_width(DW)) vif();

  cordic_vectoring #(.data_width(DW), .iterations(IT), .guard_bits(3)) dut (
    .clk   (clk),
    .reset (rst_n),
    .vif   (vif)
  );

  always #5 clk = ~clk;

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int wrapd(input int d);
    if (d > 25736)  return d - 51472;
    if (d < -25736) return d + 51472;
    return d;
  endfunction

  function automatic int ref_mag(input int x, input int y);
    real m;
    m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * kgain;
`ifdef CORDIC_GAIN_COMP_EN
    m = m * 19899.0 / 32768.0;
`endif
    if (m > 32767.0) return 32767;
    return int'(m);
  endfunction

  function automatic int ref_ang(input int x, input int y);
    return int'($atan2(real'(y), real'(x)) * 8192.0);
  endfunction

  task automatic run_one(input int x, input int y, output int rx, output int rz,
                         output int lat, output bit held);
    @(negedge clk);
    vif.enable = 1'b1;
    vif.xin    = 16'(x);
    vif.yin    = 16'(y);
    lat = -1; rx = 0; rz = 0; held = 1'b0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      vif.enable = 1'b0;
      if (vif.done === 1'b1) begin
        lat = c;
        rx  = vif.xout;
        rz  = vif.zout;
      end
    end
    if (lat > 0) begin
      @(negedge clk);
      held = (vif.done === 1'b0) && (vif.xout == rx) && (vif.zout == rz);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (vif.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", vif.done); end
    n_checks++; if (vif.xout !== 16'sd0) begin n_fail++; $display("FAIL reset_xout: got %0d want 0", vif.xout); end
    n_checks++; if (vif.zout !== 16'sd0) begin n_fail++; $display("FAIL reset_zout: got %0d want 0", vif.zout); end
    rst_n = 1'b1;
  endtask

  task automatic test_axis();
    int rx, rz, lat; bit held;
    run_one(8192, 0, rx, rz, lat, held);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL axis_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (absi(rz) > 2) begin n_fail++; $display("FAIL axis_zout: got %0d want 0+-2", rz); end
    n_checks++; if (absi(rx - MAG1) > 4) begin n_fail++; $display("FAIL axis_xout: got %0d want %0d+-4", rx, MAG1); end
    n_checks++; if (!held) begin n_fail++; $display("FAIL axis_pulse_hold: done not a 1-cycle pulse or outputs moved"); end
  endtask

  task automatic test_diag();
    int rx, rz, lat; bit held;
    run_one(8192, 8192, rx, rz, lat, held);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL diag_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (absi(rz - 6434) > 2) begin n_fail++; $display("FAIL diag_zout: got %0d want 6434+-2", rz); end
    n_checks++; if (absi(rx - MAGD) > 4) begin n_fail++; $display("FAIL diag_xout: got %0d want %0d+-4", rx, MAGD); end
  endtask

  task automatic test_quadrants();
    int rx, rz, lat; bit held;
    run_one(-8192, 0, rx, rz, lat, held);
    n_checks++; if (absi(wrapd(rz - 25736)) > 2 || rz < 0) begin n_fail++; $display("FAIL q2_zout: got %0d want 25736+-2", rz); end
    n_checks++; if (absi(rx - MAG1) > 4) begin n_fail++; $display("FAIL q2_xout: got %0d want %0d+-4", rx, MAG1); end
    run_one(0, -8192, rx, rz, lat, held);
    n_checks++; if (absi(rz + 12868) > 2) begin n_fail++; $display("FAIL q4_zout: got %0d want -12868+-2", rz); end
    n_checks++; if (absi(rx - MAG1) > 4) begin n_fail++; $display("FAIL q4_xout: got %0d want %0d+-4", rx, MAG1); end
  endtask

  task automatic test_zero();
    int rx, rz, lat; bit held;
    run_one(0, 0, rx, rz, lat, held);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL zero_done: latency %0d want %0d", lat, LAT); end
    n_checks++; if (rx != 0) begin n_fail++; $display("FAIL zero_xout: got %0d want 0", rx); end
    n_checks++; if (rz != 0) begin n_fail++; $display("FAIL zero_zout: got %0d want 0", rz); end
  endtask

  task automatic test_saturate();
    int rx, rz, lat; bit held;
    run_one(-32768, -32768, rx, rz, lat, held);
    n_checks++; if (rx != 32767) begin n_fail++; $display("FAIL sat_xout: got %0d want 32767", rx); end
    n_checks++; if (absi(rz + 19302) > 2) begin n_fail++; $display("FAIL sat_zout: got %0d want -19302+-2", rz); end
  endtask

  task automatic test_back_to_back();
    bit  pat [NV];
    int  vx [NV];
    int  vy [NV];
    int  qx [$];
    int  qy [$];
    int  ex, ey, gx, gz;
    bit  exp_d;
    real th, r;
    for (int i = 0; i < NV; i++) begin
      pat[i] = (i < 16) ? 1'b1 : !((i - 16) == 1 || (i - 16) == 4);
      th     = 0.3 + 0.3927 * i;
      r      = 8000.0 + 400.0 * i;
      vx[i]  = int'(r * $cos(th));
      vy[i]  = int'(r * $sin(th));
    end
    for (int c = 0; c < NV + LAT + 3; c++) begin
      @(negedge clk);
      exp_d = (c >= LAT && c - LAT < NV) ? pat[c-LAT] : 1'b0;
      n_checks++;
      if (vif.done !== exp_d) begin n_fail++; $display("FAIL b2b_done cycle %0d: got %b want %b", c, vif.done, exp_d); end
      if (vif.done === 1'b1) begin
        if (qx.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL b2b_order: done with no outstanding vector at cycle %0d", c);
        end else begin
          ex = qx.pop_front(); ey = qy.pop_front();
          gx = vif.xout; gz = vif.zout;
          n_checks++;
          if (absi(gx - ref_mag(ex, ey)) > 6) begin n_fail++; $display("FAIL b2b_xout (%0d,%0d): got %0d want %0d+-6", ex, ey, gx, ref_mag(ex, ey)); end
          n_checks++;
          if (absi(wrapd(gz - ref_ang(ex, ey))) > 4) begin n_fail++; $display("FAIL b2b_zout (%0d,%0d): got %0d want %0d+-4", ex, ey, gz, ref_ang(ex, ey)); end
        end
      end
      if (c < NV) begin
        vif.enable = pat[c];
        vif.xin    = 16'(vx[c]);
        vif.yin    = 16'(vy[c]);
        if (pat[c]) begin qx.push_back(vx[c]); qy.push_back(vy[c]); end
      end else begin
        vif.enable = 1'b0;
      end
    end
    n_checks++; if (qx.size() != 0) begin n_fail++; $display("FAIL b2b_missing: %0d results never appeared", qx.size()); end
  endtask

  task automatic test_reset_flight();
    int rx, rz, lat; bit held, seen;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vif.enable = 1'b1;
      vif.xin    = 16'sd8192;
      vif.yin    = 16'(1000 * k);
    end
    @(negedge clk);
    vif.enable = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (vif.done !== 1'b0) begin n_fail++; $display("FAIL flight_done: got %b want 0", vif.done); end
    n_checks++; if (vif.xout !== 16'sd0) begin n_fail++; $display("FAIL flight_xout: got %0d want 0 before clock", vif.xout); end
    n_checks++; if (vif.zout !== 16'sd0) begin n_fail++; $display("FAIL flight_zout: got %0d want 0 before clock", vif.zout); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (vif.done === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL flight_ghost_done: got done after reset, want none"); end
    run_one(8192, 8192, rx, rz, lat, held);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL flight_restart_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (absi(rz - 6434) > 2) begin n_fail++; $display("FAIL flight_restart_zout: got %0d want 6434+-2", rz); end
  endtask

  initial begin
    real p;
    p = 1.0;
    for (int i = 0; i < IT; i++) begin
      kgain = kgain * $sqrt(1.0 + p);
      p     = p / 4.0;
    end
    vif.enable = 1'b0;
    vif.xin    = '0;
    vif.yin    = '0;
    test_reset();
    test_axis();
    test_diag();
    test_quadrants();
    test_zero();
    test_saturate();
    test_back_to_back();
    test_reset_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cordic_vectoring.md
Name: cordic_vectoring

Overview:
- Pipelined circular CORDIC in vectoring mode; the inverse direction of the existing rotation core.
- The rotation core maps an angle to (x, y). This block maps a vector (xin, yin) to its magnitude (xout) and angle (zout, atan2).
- Sits beside the rotation core in the datapath and uses the same fixed-point formats and enable/done handshake.
- Fully pipelined: accepts one vector per clock.

Parameters:
- data_width, 16, width of all data ports; Q3.13 signed (1.0 = 8192, pi = 25736).
- iterations, 14, number of micro-rotation stages; valid range 8..data_width-1.
- guard_bits, 3, extra MSBs on the internal x/y datapath for CORDIC gain and quadrant growth.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  input valid; xin/yin are sampled on every rising edge where enable=1.
- xin  in  data_width  signed x component, Q3.13.
- yin  in  data_width  signed y component, Q3.13.
- done  out  1  output valid; one-cycle pulse per accepted vector.
- xout  out  data_width  signed magnitude, Q3.13, saturated.
- zout  out  data_width  signed angle, Q3.13 radians, range (-pi, pi].

Behaviour:
- Reset (reset=0, asynchronous): all stage valid bits, done, xout and zout are cleared to 0. Vectors in flight are discarded and never produce done.
- Stage 0, registered quadrant pre-rotation:
  - xin>=0: x=xin, y=yin, z=0.
  - xin<0 and yin>=0: x=yin, y=-xin, z=+12868 (pi/2).
  - xin<0 and yin<0: x=-yin, y=xin, z=-12868.
  - Inputs are sign-extended to data_width+guard_bits before negation, so -32768 does not overflow.
- Stage i (i=0..iterations-1), one register each:
  - y>=0: x+=y>>>i; y-=x>>>i; z+=ATAN[i].
  - y<0: x-=y>>>i; y+=x>>>i; z-=ATAN[i].
  - Shifts are arithmetic. x and y updates use the previous-stage values.
  - z is data_width wide; it cannot overflow because |z| < 1.75*8192 + 12868.
- Output stage, one register:
  - xout = saturate(x) to [-32768, 32767], or the gain-compensated value (see Optional Feature).
  - zout = z. If z equals -25736 (exactly -pi), zout = +25736.
- Latency: done rises exactly iterations+2 cycles after the enable edge (16 cycles at default). Throughput is one vector per cycle.
- Each stage carries a valid bit. enable=0 inserts a bubble, which reappears on done iterations+2 cycles later.
- xout and zout update only on cycles where the final valid bit is 1; otherwise they hold their last value.
- Zero vector: a zero flag (xin==0 && yin==0) travels with the data. When set, the output stage forces xout=0 and zout=0.
- No backpressure; the consumer must accept done pulses as they arrive.

Optional Feature:
- CORDIC_GAIN_COMP_EN defined:
  - The output stage multiplies x by INV_K = 19899 (1/K in Q1.15), rounds half-up, shifts right by 15, then saturates.
  - The multiply sits in the same register stage, so latency is unchanged.
- Not defined: xout is the raw magnitude scaled by K ≈ 1.6468, saturated.

Decomposition:
- Package cordic_pkg holds:
  - ATAN table as localparams in Q3.13: 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, continuing with 1 where required.
  - PI = 25736, HALF_PI = 12868, INV_K = 19899.
  - The Q-format fractional-bit constant (13).
- One sub-module, cordic_vec_stage: a single micro-rotation register stage with the shift amount and ATAN value as parameters. It is instantiated iterations times in a generate loop.

Test Plan:
- xin=8192, yin=0, single enable pulse -> done exactly 16 cycles later; zout=0 ±2; xout=8192 ±4 (comp) or 13491 ±4 (raw).
- xin=8192, yin=8192 -> zout=6434 ±2; xout=11585 ±4 (comp).
- xin=-8192, yin=0 -> zout=+25736 ±2; then xin=0, yin=-8192 -> zout=-12868 ±2; xout=8192 ±4 (comp) in both cases.
- enable held high for 16 cycles with swept vectors, then pattern 1,0,1,1,0 -> 16 consecutive done pulses in input order, then the same 1,0,1,1,0 pattern on done. Each result matches a reference model.
- xin=yin=0 -> xout=0, zout=0, done asserted. xin=yin=-32768 in raw mode -> xout=32767 (saturated), zout=-19302 ±2.
- reset driven low for 2 cycles while 5 vectors are in flight -> done, xout, zout go to 0 immediately without waiting for a clock edge. No done pulses appear after reset is released until a new enable.
